// File: rtl/trans_tracker.sv
// Multi-channel saturating occupancy tracker with full/empty/almost flags and sticky errors.
// Define TRANS_TRACKER_HWM_EN to add the per-channel high-water-mark output hwm.
module trans_tracker #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MAX_VALUE  = 255,
  parameter int unsigned AFULL_LVL  = 240,
  parameter int unsigned AEMPTY_LVL = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       clr,
  input  logic [NUM_CH-1:0]       inc,
  input  logic [NUM_CH-1:0]       dec,
  input  logic                    err_clr,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH-1:0]       full,
  output logic [NUM_CH-1:0]       empty,
  output logic [NUM_CH-1:0]       afull,
  output logic [NUM_CH-1:0]       aempty,
  output logic [NUM_CH-1:0]       ovf_err,
`ifdef TRANS_TRACKER_HWM_EN
  output logic [NUM_CH*WIDTH-1:0] hwm,
`endif
  output logic [NUM_CH-1:0]       udf_err
);

  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] AFULL_W  = WIDTH'(AFULL_LVL);
  localparam logic [WIDTH-1:0] AEMPTY_W = WIDTH'(AEMPTY_LVL);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLR,
    OP_INC,
    OP_DEC
  } op_e;

  // Per-channel priority: clr > (inc & dec, net zero) > inc > dec.
  function automatic op_e decode_op(input logic c, input logic i, input logic d);
    if (c)           return OP_CLR;
    else if (i && d) return OP_HOLD;
    else if (i)      return OP_INC;
    else if (d)      return OP_DEC;
    else             return OP_HOLD;
  endfunction

  logic [WIDTH-1:0]  count_q [NUM_CH];
  logic [WIDTH-1:0]  count_d [NUM_CH];
  logic [NUM_CH-1:0] full_q, full_d;
  logic [NUM_CH-1:0] empty_q, empty_d;
  logic [NUM_CH-1:0] afull_q, afull_d;
  logic [NUM_CH-1:0] aempty_q, aempty_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [NUM_CH-1:0] udf_q, udf_d;
`ifdef TRANS_TRACKER_HWM_EN
  logic [WIDTH-1:0]  hwm_q [NUM_CH];
  logic [WIDTH-1:0]  hwm_d [NUM_CH];
`endif

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      // NOTE: every next-state signal gets a default before any branch so no latch is inferred.
      count_d[ch] = count_q[ch];
      ovf_d[ch]   = ovf_q[ch] & ~err_clr;
      udf_d[ch]   = udf_q[ch] & ~err_clr;

      unique case (decode_op(clr[ch], inc[ch], dec[ch]))
        OP_CLR:  count_d[ch] = '0;
        OP_INC: begin
          if (count_q[ch] >= MAX_W) ovf_d[ch] = 1'b1;
          else                      count_d[ch] = count_q[ch] + ONE_W;
        end
        OP_DEC: begin
          if (count_q[ch] == '0) udf_d[ch] = 1'b1;
          else                   count_d[ch] = count_q[ch] - ONE_W;
        end
        default: ;
      endcase

      // Flags come from the next count so they move on the same edge as count.
      full_d[ch]   = (count_d[ch] == MAX_W);
      empty_d[ch]  = (count_d[ch] == '0);
      afull_d[ch]  = (count_d[ch] >= AFULL_W);
      aempty_d[ch] = (count_d[ch] <= AEMPTY_W);
`ifdef TRANS_TRACKER_HWM_EN
      if (clr[ch])                       hwm_d[ch] = '0;
      else if (count_d[ch] > hwm_q[ch])  hwm_d[ch] = count_d[ch];
      else                               hwm_d[ch] = hwm_q[ch];
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        count_q[ch] <= '0;
`ifdef TRANS_TRACKER_HWM_EN
        hwm_q[ch]   <= '0;
`endif
      end
      full_q   <= '0;
      empty_q  <= '1;
      afull_q  <= '0;
      aempty_q <= '1;
      ovf_q    <= '0;
      udf_q    <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        count_q[ch] <= count_d[ch];
`ifdef TRANS_TRACKER_HWM_EN
        hwm_q[ch]   <= hwm_d[ch];
`endif
      end
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign count[g*WIDTH +: WIDTH] = count_q[g];
`ifdef TRANS_TRACKER_HWM_EN
    assign hwm[g*WIDTH +: WIDTH]   = hwm_q[g];
`endif
  end

  assign full    = full_q;
  assign empty   = empty_q;
  assign afull   = afull_q;
  assign aempty  = aempty_q;
  assign ovf_err = ovf_q;
  assign udf_err = udf_q;

endmodule

// File: tb/tb_trans_tracker.sv
// Scoreboard bench for trans_tracker: driver pushes expected state, monitor pops and compares.
// hwm checks are compiled in only when TRANS_TRACKER_HWM_EN is defined.
module tb_trans_tracker;

  localparam int NUM_CH = 2;
  localparam int WIDTH  = 8;
  localparam int MAXV   = 255;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_CH-1:0]       clr = '0;
  logic [NUM_CH-1:0]       inc = '0;
  logic [NUM_CH-1:0]       dec = '0;
  logic                    err_clr = 1'b0;
  logic [NUM_CH*WIDTH-1:0] count;
  logic [NUM_CH-1:0]       full, empty, afull, aempty, ovf_err, udf_err;
`ifdef TRANS_TRACKER_HWM_EN
  logic [NUM_CH*WIDTH-1:0] hwm;
`endif

  trans_tracker dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .inc     (inc),
    .dec     (dec),
    .err_clr (err_clr),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .afull   (afull),
    .aempty  (aempty),
    .ovf_err (ovf_err),
`ifdef TRANS_TRACKER_HWM_EN
    .hwm     (hwm),
`endif
    .udf_err (udf_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int                    step;
    logic [NUM_CH*WIDTH-1:0] cnt;
    logic [NUM_CH*WIDTH-1:0] hw;
    logic [NUM_CH-1:0]     full;
    logic [NUM_CH-1:0]     empty;
    logic [NUM_CH-1:0]     afull;
    logic [NUM_CH-1:0]     aempty;
    logic [NUM_CH-1:0]     ovf;
    logic [NUM_CH-1:0]     udf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step_no  = 0;

  // Reference model state
  int m_cnt [NUM_CH];
  int m_hwm [NUM_CH];
  bit m_ovf [NUM_CH];
  bit m_udf [NUM_CH];

  task automatic check(input string name, input int step, input int ch,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d ch%0d: got %0d expected %0d", name, step, ch, act, exp);
  endtask

  task automatic step(input bit r, input logic [1:0] c, input logic [1:0] i,
                      input logic [1:0] d, input bit e);
    exp_t x;
    @(negedge clk);
    rst = r; clr = c; inc = i; dec = d; err_clr = e;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (r) begin
        m_cnt[ch] = 0; m_hwm[ch] = 0; m_ovf[ch] = 0; m_udf[ch] = 0;
      end else begin
        if (e) begin m_ovf[ch] = 0; m_udf[ch] = 0; end
        if (c[ch]) begin
          m_cnt[ch] = 0; m_hwm[ch] = 0;
        end else if (i[ch] && !d[ch]) begin
          if (m_cnt[ch] == MAXV) m_ovf[ch] = 1; else m_cnt[ch] += 1;
        end else if (d[ch] && !i[ch]) begin
          if (m_cnt[ch] == 0) m_udf[ch] = 1; else m_cnt[ch] -= 1;
        end
        if (m_cnt[ch] > m_hwm[ch]) m_hwm[ch] = m_cnt[ch];
      end
      x.cnt[ch*WIDTH +: WIDTH] = m_cnt[ch][WIDTH-1:0];
      x.hw[ch*WIDTH +: WIDTH]  = m_hwm[ch][WIDTH-1:0];
      x.full[ch]   = (m_cnt[ch] == MAXV);
      x.empty[ch]  = (m_cnt[ch] == 0);
      x.afull[ch]  = (m_cnt[ch] >= 240);
      x.aempty[ch] = (m_cnt[ch] <= 4);
      x.ovf[ch]    = m_ovf[ch];
      x.udf[ch]    = m_udf[ch];
    end
    x.step = step_no++;
    sb.push_back(x);
    @(posedge clk);
  endtask

  task automatic repeat_step(input int n, input logic [1:0] i, input logic [1:0] d);
    for (int k = 0; k < n; k++) step(1'b0, 2'b00, i, d, 1'b0);
  endtask

  // Monitor: every cycle the DUT presents a fresh registered state; compare against the head.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        for (int ch = 0; ch < NUM_CH; ch++) begin
          check("count",   x.step, ch, 32'(count[ch*WIDTH +: WIDTH]), 32'(x.cnt[ch*WIDTH +: WIDTH]));
          check("full",    x.step, ch, 32'(full[ch]),    32'(x.full[ch]));
          check("empty",   x.step, ch, 32'(empty[ch]),   32'(x.empty[ch]));
          check("afull",   x.step, ch, 32'(afull[ch]),   32'(x.afull[ch]));
          check("aempty",  x.step, ch, 32'(aempty[ch]),  32'(x.aempty[ch]));
          check("ovf_err", x.step, ch, 32'(ovf_err[ch]), 32'(x.ovf[ch]));
          check("udf_err", x.step, ch, 32'(udf_err[ch]), 32'(x.udf[ch]));
`ifdef TRANS_TRACKER_HWM_EN
          check("hwm",     x.step, ch, 32'(hwm[ch*WIDTH +: WIDTH]), 32'(x.hw[ch*WIDTH +: WIDTH]));
`endif
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // 1: reset, three increments on ch0
    step(1'b1, 2'b00, 2'b00, 2'b00, 1'b0);
    repeat_step(3, 2'b01, 2'b00);
    // 2: fill ch0 to the ceiling, one extra increment saturates and sets ovf
    repeat_step(252, 2'b01, 2'b00);
    step(1'b0, 2'b00, 2'b01, 2'b00, 1'b0);
    // 3: underflow ch1, then inc&dec at 0 (ch1) and at 255 (ch0)
    step(1'b0, 2'b00, 2'b00, 2'b10, 1'b0);
    step(1'b0, 2'b00, 2'b11, 2'b11, 1'b0);
    // 4: err_clr with a concurrent overflow keeps ovf; plain err_clr clears
    step(1'b0, 2'b00, 2'b01, 2'b00, 1'b1);
    step(1'b0, 2'b00, 2'b00, 2'b00, 1'b1);
    step(1'b0, 2'b01, 2'b00, 2'b00, 1'b0);
    repeat_step(100, 2'b01, 2'b00);
    step(1'b0, 2'b01, 2'b01, 2'b00, 1'b0);
    // clr on a channel at 0 with dec: no underflow
    step(1'b0, 2'b01, 2'b00, 2'b01, 1'b0);
    // 5: ch1 to 5 then dec to 4 (aempty rises); ch0 to 50 then rst
    repeat_step(5, 2'b10, 2'b00);
    step(1'b0, 2'b00, 2'b00, 2'b10, 1'b0);
    repeat_step(50, 2'b01, 2'b00);
    step(1'b1, 2'b00, 2'b11, 2'b00, 1'b0);
    // 6: high-water mark: ch1 up to 10, down to 2, then clr
    repeat_step(10, 2'b10, 2'b00);
    repeat_step(8, 2'b00, 2'b10);
    step(1'b0, 2'b10, 2'b00, 2'b00, 1'b0);
    // mixed activity on both channels
    step(1'b0, 2'b00, 2'b11, 2'b00, 1'b0);
    step(1'b0, 2'b00, 2'b01, 2'b10, 1'b0);
    step(1'b0, 2'b00, 2'b00, 2'b11, 1'b0);
    step(1'b0, 2'b00, 2'b00, 2'b11, 1'b0);

    @(negedge clk);
    rst = 1'b0; clr = '0; inc = '0; dec = '0; err_clr = 1'b0;
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #2;
    check("drain", step_no, 0, 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
